index_vector_builder: RTL and testbench

Stream-to-vector decoder: accepts a sequence of bit indices over a valid/ready handshake, decodes each to one-hot, and ORs them into a VECTOR_LENGTH-bit accumulator. When the beat marked last is accepted, the assembled vector moves to a one-entry output register and is presented on a second valid/ready handshake. It is the inverse of the index-search path: it turns index streams into request/valid masks for downstream priority logic.

---
 rtl/index_vector_builder.sv | 77 +++++++
 tb/tb_index_vector_builder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/index_vector_builder.sv
// Stream-to-vector decoder: ORs one-hot decoded index beats into an accumulator
// and hands each completed set to a one-entry output register.
module index_vector_builder #(
    parameter int unsigned VECTOR_LENGTH   = 8,
    parameter int unsigned MAX_INPUT_WIDTH = 32
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic [MAX_INPUT_WIDTH-1:0] index_in,
    input  logic                       index_last_in,
    input  logic                       index_valid_in,
    output logic                       index_ready_out,
    output logic [VECTOR_LENGTH-1:0]   vector_out,
    output logic                       duplicate_out,
    output logic                       out_of_range_out,
    output logic                       vector_valid_out,
    input  logic                       vector_ready_in
);

    localparam logic [MAX_INPUT_WIDTH-1:0] LIMIT = MAX_INPUT_WIDTH'(VECTOR_LENGTH);

    logic [VECTOR_LENGTH-1:0] acc;
    logic                     dup_acc;
    logic                     oor_acc;
    logic [VECTOR_LENGTH-1:0] onehot;
    logic                     in_range;
    logic                     hit;
    logic                     accept;
    logic                     consume;

    // Decode against the full-width index so large values never alias onto a low bit.
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < VECTOR_LENGTH; i++) begin
            onehot[i] = (index_in == MAX_INPUT_WIDTH'(i));
        end
    end

    assign in_range        = (index_in < LIMIT);
    assign hit             = |(acc & onehot);
    assign index_ready_out = reset_in & (~vector_valid_out | vector_ready_in);
    assign accept          = index_valid_in & index_ready_out;
    assign consume         = vector_valid_out & vector_ready_in;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            acc              <= '0;
            dup_acc          <= 1'b0;
            oor_acc          <= 1'b0;
            vector_out       <= '0;
            duplicate_out    <= 1'b0;
            out_of_range_out <= 1'b0;
            vector_valid_out <= 1'b0;
        end else begin
            if (consume) begin
                vector_valid_out <= 1'b0;
            end
            // A last beat on a consume edge overrides the clear above: no bubble.
            if (accept) begin
                if (index_last_in) begin
                    vector_out       <= acc | onehot;
                    duplicate_out    <= dup_acc | hit;
                    out_of_range_out <= oor_acc | ~in_range;
                    vector_valid_out <= 1'b1;
                    acc              <= '0;
                    dup_acc          <= 1'b0;
                    oor_acc          <= 1'b0;
                end else begin
                    acc     <= acc | onehot;
                    dup_acc <= dup_acc | hit;
                    oor_acc <= oor_acc | ~in_range;
                end
            end
        end
    end

endmodule

// File: tb/tb_index_vector_builder.sv
// Directed, table-driven bench for index_vector_builder with hand-computed expectations.
module tb_index_vector_builder;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [31:0] index_in;
    logic        index_last_in;
    logic        index_valid_in;
    logic        index_ready_out;
    logic [7:0]  vector_out;
    logic        duplicate_out;
    logic        out_of_range_out;
    logic        vector_valid_out;
    logic        vector_ready_in;

    int n_cmp  = 0;
    int n_fail = 0;

    index_vector_builder #(
        .VECTOR_LENGTH   (8),
        .MAX_INPUT_WIDTH (32)
    ) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .index_in         (index_in),
        .index_last_in    (index_last_in),
        .index_valid_in   (index_valid_in),
        .index_ready_out  (index_ready_out),
        .vector_out       (vector_out),
        .duplicate_out    (duplicate_out),
        .out_of_range_out (out_of_range_out),
        .vector_valid_out (vector_valid_out),
        .vector_ready_in  (vector_ready_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] idx;
        logic        last;
        logic        vr;
        logic        e_ready;
        logic        e_vv;
        logic [7:0]  e_vec;
        logic        e_dup;
        logic        e_oor;
    } row_t;

    row_t tbl[$];

    task automatic add(input logic rst, input logic v, input logic [31:0] idx,
                       input logic last, input logic vr, input logic e_ready,
                       input logic e_vv, input logic [7:0] e_vec,
                       input logic e_dup, input logic e_oor);
        row_t r;
        r = '{rst, v, idx, last, vr, e_ready, e_vv, e_vec, e_dup, e_oor};
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle: ready is checked before the edge, registered outputs after it.
    task automatic step(input string tag, input row_t r);
        reset_in       = r.rst;
        index_valid_in = r.v;
        index_in       = r.idx;
        index_last_in  = r.last;
        vector_ready_in = r.vr;
        @(negedge clk_in);
        check({tag, " ready"}, {31'b0, index_ready_out}, {31'b0, r.e_ready});
        @(posedge clk_in);
        #1;
        check({tag, " valid"}, {31'b0, vector_valid_out}, {31'b0, r.e_vv});
        check({tag, " vec"},   {24'b0, vector_out},       {24'b0, r.e_vec});
        check({tag, " dup"},   {31'b0, duplicate_out},    {31'b0, r.e_dup});
        check({tag, " oor"},   {31'b0, out_of_range_out}, {31'b0, r.e_oor});
    endtask

    initial begin
        reset_in        = 1'b0;
        index_valid_in  = 1'b0;
        index_in        = '0;
        index_last_in   = 1'b0;
        vector_ready_in = 1'b0;

        //   rst v  idx        last vr  rdy vv  vec    dup oor
        // reset held with a valid beat offered, then release
        add(0, 1, 32'd3,     1, 1,  0,  0,  8'h00, 0, 0);
        add(0, 1, 32'd3,     1, 1,  0,  0,  8'h00, 0, 0);
        add(1, 0, 32'd0,     0, 1,  1,  0,  8'h00, 0, 0);
        // single-beat sets
        add(1, 1, 32'd0,     1, 1,  1,  1,  8'h01, 0, 0);
        add(1, 0, 32'd0,     0, 1,  1,  0,  8'h01, 0, 0);
        add(1, 1, 32'd7,     1, 1,  1,  1,  8'h80, 0, 0);
        add(1, 0, 32'd0,     0, 1,  1,  0,  8'h80, 0, 0);
        // multi-beat set 4,7,0
        add(1, 1, 32'd4,     0, 1,  1,  0,  8'h80, 0, 0);
        add(1, 1, 32'd7,     0, 1,  1,  0,  8'h80, 0, 0);
        add(1, 1, 32'd0,     1, 1,  1,  1,  8'h91, 0, 0);
        add(1, 0, 32'd0,     0, 1,  1,  0,  8'h91, 0, 0);
        // flags per set
        add(1, 1, 32'd3,     0, 1,  1,  0,  8'h91, 0, 0);
        add(1, 1, 32'd3,     1, 1,  1,  1,  8'h08, 1, 0);
        add(1, 1, 32'd8,     1, 1,  1,  1,  8'h00, 0, 1);
        add(1, 1, 32'd2,     1, 1,  1,  1,  8'h04, 0, 0);
        add(1, 0, 32'd0,     0, 1,  1,  0,  8'h04, 0, 0);
        // wide index whose low byte would alias to bit 0
        add(1, 1, 32'h100,   1, 1,  1,  1,  8'h00, 0, 1);
        add(1, 0, 32'd0,     0, 1,  1,  0,  8'h00, 0, 1);
        // valid gap mid-set with a different index present
        add(1, 1, 32'd6,     0, 1,  1,  0,  8'h00, 0, 1);
        add(1, 0, 32'd1,     1, 1,  1,  0,  8'h00, 0, 1);
        add(1, 1, 32'd6,     1, 1,  1,  1,  8'h40, 1, 0);
        add(1, 0, 32'd0,     0, 1,  1,  0,  8'h40, 1, 0);
        // backpressure on a pending vector, then consume + last same edge
        add(1, 1, 32'd1,     1, 0,  1,  1,  8'h02, 0, 0);
        add(1, 1, 32'd5,     1, 0,  0,  1,  8'h02, 0, 0);
        add(1, 1, 32'd5,     1, 0,  0,  1,  8'h02, 0, 0);
        add(1, 1, 32'd5,     1, 0,  0,  1,  8'h02, 0, 0);
        add(1, 1, 32'd5,     1, 1,  1,  1,  8'h20, 0, 0);
        add(1, 0, 32'd0,     0, 1,  1,  0,  8'h20, 0, 0);
        // non-last beat stalls, resumes on the consume edge
        add(1, 1, 32'd3,     1, 0,  1,  1,  8'h08, 0, 0);
        add(1, 1, 32'd4,     0, 0,  0,  1,  8'h08, 0, 0);
        add(1, 1, 32'd4,     0, 1,  1,  0,  8'h08, 0, 0);
        add(1, 1, 32'd2,     1, 1,  1,  1,  8'h14, 0, 0);
        add(1, 0, 32'd0,     0, 1,  1,  0,  8'h14, 0, 0);
        // reset mid-set discards 2 and 5
        add(1, 1, 32'd2,     0, 1,  1,  0,  8'h14, 0, 0);
        add(1, 1, 32'd5,     0, 1,  1,  0,  8'h14, 0, 0);
        add(0, 0, 32'd0,     0, 1,  0,  0,  8'h00, 0, 0);
        add(1, 1, 32'd1,     1, 1,  1,  1,  8'h02, 0, 0);
        add(1, 0, 32'd0,     0, 1,  1,  0,  8'h02, 0, 0);
        // pending vector dropped by reset never appears
        add(1, 1, 32'd4,     1, 0,  1,  1,  8'h10, 0, 0);
        add(0, 0, 32'd0,     0, 0,  0,  0,  8'h00, 0, 0);
        add(1, 0, 32'd0,     0, 1,  1,  0,  8'h00, 0, 0);

        foreach (tbl[i]) begin
            step($sformatf("row%0d", i), tbl[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
